// File: rtl/lsu_if.sv
// Bundles for the load/store unit: execute-side request/response
// and the sram-side strobe/data port.
//
// lsu_req_if : execute (master) <-> lsu (slave)
//   req_valid/req_ready handshake carrying wen, funct3, addr, wdata;
//   resp_valid/resp_ready handshake carrying rdata and err.
// lsu_mem_if : lsu (master) <-> sram (slave)
//   ren/wen strobes with addr, wmask, wdata; sram returns rdata/valid.

interface lsu_req_if #(
   parameter int DW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_wen;
   logic [2:0]    req_funct3;
   logic [DW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;

   modport master (
      output req_valid, req_wen, req_funct3, req_addr, req_wdata,
      output resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
      input  resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_mem_if #(
   parameter int DW = 32
);
   logic          mem_ren;
   logic          mem_wen;
   logic [7:0]    mem_wmask;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_valid;

   modport master (
      output mem_ren, mem_wen, mem_wmask, mem_addr, mem_wdata,
      input  mem_rdata, mem_valid
   );

   modport slave (
      input  mem_ren, mem_wen, mem_wmask, mem_addr, mem_wdata,
      output mem_rdata, mem_valid
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time from execute, drives the sram
// strobes, extracts/extends load data, returns a registered response.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   req  : lsu_req_if.slave  (request in, response out)
//   mem  : lsu_mem_if.master (sram ren/wen/addr/wmask/wdata, rdata/valid)

module lsu #(
   parameter int DW = 32
) (
   input  logic      clk,
   input  logic      rst,
   lsu_req_if.slave  req,
   lsu_mem_if.master mem
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RD     = 3'd1;
   localparam logic [2:0] S_WR     = 3'd2;
   localparam logic [2:0] S_WAIT_W = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [3:0]    wmask_q, wmask_d;
   logic [1:0]    off_q, off_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic          err_q, err_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic          accept;
   logic [1:0]    req_off;
   logic [1:0]    req_size;
   logic [3:0]    req_mask;
   logic          req_mis;
   logic [DW-1:0] ld_lane;
   logic [DW-1:0] ld_ext;

   assign accept  = req.req_valid & (state_q == S_IDLE);
   assign req_off = req.req_addr[1:0];

   // Undefined width codes fall through to word.
   always_comb begin
      unique case (req.req_funct3[1:0])
         2'b00: begin
            req_size = SZ_B;
            req_mask = 4'b0001 << req_off;
         end
         2'b01: begin
            req_size = SZ_H;
            req_mask = 4'b0011 << req_off;
         end
         default: begin
            req_size = SZ_W;
            req_mask = 4'b1111;
         end
      endcase
   end

   assign req_mis = ((req_size == SZ_H) & req_off[0])
                  | ((req_size == SZ_W) & (|req_off));

   assign ld_lane = mem.mem_rdata >> {off_q, 3'b000};

   always_comb begin
      unique case (size_q)
         SZ_B:    ld_ext = {{(DW-8){ld_lane[7] & ~uns_q}},
                            ld_lane[7:0]};
         SZ_H:    ld_ext = {{(DW-16){ld_lane[15] & ~uns_q}},
                            ld_lane[15:0]};
         default: ld_ext = ld_lane;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      off_d   = off_q;
      size_d  = size_q;
      uns_d   = uns_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d  = {req.req_addr[DW-1:2], 2'b00};
               wdata_d = req.req_wdata << {req_off, 3'b000};
               wmask_d = req_mask;
               off_d   = req_off;
               size_d  = req_size;
               uns_d   = req.req_funct3[2];
               err_d   = req_mis;
               rdata_d = '0;
               if (req_mis)
                  state_d = S_RESP;
               else if (req.req_wen)
                  state_d = S_WR;
               else
                  state_d = S_RD;
            end
         end
         S_RD: begin
            if (mem.mem_valid) begin
               rdata_d = ld_ext;
               state_d = S_RESP;
            end
         end
         S_WR: begin
            state_d = S_WAIT_W;
         end
         S_WAIT_W: begin
            if (mem.mem_valid)
               state_d = S_RESP;
         end
         S_RESP: begin
            // Stale sram valid after ren drops lands here and is ignored.
            if (req.resp_ready)
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         off_q   <= '0;
         size_q  <= SZ_W;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         off_q   <= off_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign req.req_ready  = (state_q == S_IDLE);
   assign req.resp_valid = (state_q == S_RESP);
   assign req.resp_err   = err_q & (state_q == S_RESP);
   assign req.resp_rdata = rdata_q;

   assign mem.mem_ren   = (state_q == S_RD);
   assign mem.mem_wen   = (state_q == S_WR);
   assign mem.mem_wmask = (state_q == S_WR) ? {4'b0000, wmask_q} : 8'h00;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, misaligned, back-to-back,
// response backpressure and asynchronous reset mid-access.

module tb_lsu;

   logic clk;
   logic rst;

   lsu_req_if rq ();
   lsu_mem_if mm ();

   lsu u_dut (
      .clk (clk),
      .rst (rst),
      .req (rq.slave),
      .mem (mm.master)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic sram_on = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // sram responder: valid follows any strobe by one cycle, so it also
   // stays high one cycle after ren drops.
   task automatic step();
      logic s;
      s = mm.mem_ren | mm.mem_wen;
      @(posedge clk);
      #1;
      mm.mem_valid = s & sram_on;
   endtask

   task automatic xact(input string       tag,
                       input logic        wen,
                       input logic [2:0]  f3,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [31:0] word,
                       input int          hold,
                       input int          exp_lat,
                       input logic [31:0] exp_rd,
                       input logic        exp_err,
                       input int          exp_ren,
                       input int          exp_wen,
                       input logic [7:0]  exp_mask,
                       input logic [31:0] exp_wd);
      int c, lat, ren_n, wen_n, rdy_n, mbad, abad;
      logic [7:0]  mask;
      logic [31:0] wdo, maddr, rd0;
      lat = 0; ren_n = 0; wen_n = 0; rdy_n = 0; mbad = 0; abad = 0;
      mask = '0; wdo = '0; maddr = '0;
      check($sformatf("%s_ready", tag), 32'(rq.req_ready), 32'd1);
      mm.mem_rdata   = word;
      rq.resp_ready  = (hold == 0);
      rq.req_valid   = 1'b1;
      rq.req_wen     = wen;
      rq.req_funct3  = f3;
      rq.req_addr    = addr;
      rq.req_wdata   = wd;
      step();
      rq.req_valid = 1'b0;
      for (c = 1; c <= 20; c++) begin
         if (mm.mem_ren) begin
            ren_n++;
            if (ren_n == 1) maddr = mm.mem_addr;
            else if (mm.mem_addr !== maddr) abad++;
         end
         if (mm.mem_wen) begin
            wen_n++;
            mask  = mm.mem_wmask;
            wdo   = mm.mem_wdata;
            maddr = mm.mem_addr;
         end else if (mm.mem_wmask !== 8'h00) begin
            mbad++;
         end
         if (rq.req_ready) rdy_n++;
         if (rq.resp_valid) begin
            lat = c;
            break;
         end
         step();
      end
      check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s_rdata", tag), rq.resp_rdata, exp_rd);
      check($sformatf("%s_err", tag), 32'(rq.resp_err), 32'(exp_err));
      check($sformatf("%s_ren_n", tag), 32'(ren_n), 32'(exp_ren));
      check($sformatf("%s_wen_n", tag), 32'(wen_n), 32'(exp_wen));
      check($sformatf("%s_busy", tag), 32'(rdy_n), 32'd0);
      check($sformatf("%s_mask0", tag), 32'(mbad + abad), 32'd0);
      if (exp_ren + exp_wen > 0)
         check($sformatf("%s_maddr", tag), maddr,
               {addr[31:2], 2'b00});
      if (exp_wen > 0) begin
         check($sformatf("%s_wmask", tag), 32'(mask), 32'(exp_mask));
         check($sformatf("%s_wdata", tag), wdo, exp_wd);
      end
      rd0 = rq.resp_rdata;
      for (int i = 0; i < hold; i++) begin
         step();
         check($sformatf("%s_hold%0d", tag, i),
               {29'd0, rq.resp_valid, rq.req_ready, rq.resp_err},
               {29'd0, 1'b1, 1'b0, exp_err});
         check($sformatf("%s_hrd%0d", tag, i), rq.resp_rdata, rd0);
      end
      rq.resp_ready = 1'b1;
      step();
      check($sformatf("%s_done", tag),
            {30'd0, rq.resp_valid, rq.req_ready}, {30'd0, 1'b0, 1'b1});
   endtask

   initial begin
      rst           = 1'b0;
      rq.req_valid  = 1'b0;
      rq.req_wen    = 1'b0;
      rq.req_funct3 = 3'b010;
      rq.req_addr   = '0;
      rq.req_wdata  = '0;
      rq.resp_ready = 1'b1;
      mm.mem_rdata  = '0;
      mm.mem_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(rq.req_ready), 32'd1);
      check("rst_strobes",
            {29'd0, mm.mem_ren, mm.mem_wen, rq.resp_valid}, 32'd0);
      check("rst_wmask", 32'(mm.mem_wmask), 32'd0);
      check("rst_addr", mm.mem_addr, 32'd0);
      check("rst_rdata", rq.resp_rdata, 32'd0);
      rst = 1'b1;
      step();

      // tag wen f3 addr wdata word hold lat rd err ren wen mask wd
      xact("lw", 0, 3'b010, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0,
           3, 32'hDEAD_BEEF, 0, 2, 0, 0, 0);
      xact("lb", 0, 3'b000, 32'h8000_0003, 0, 32'h80FF_0011, 0,
           3, 32'hFFFF_FF80, 0, 2, 0, 0, 0);
      xact("lbu", 0, 3'b100, 32'h8000_0003, 0, 32'h80FF_0011, 0,
           3, 32'h0000_0080, 0, 2, 0, 0, 0);
      xact("lh", 0, 3'b001, 32'h8000_0002, 0, 32'h80FF_0011, 0,
           3, 32'hFFFF_80FF, 0, 2, 0, 0, 0);
      xact("mis_lw", 0, 3'b010, 32'h8000_0002, 0, 32'h1111_1111, 0,
           1, 32'h0, 1, 0, 0, 0, 0);
      xact("sh", 1, 3'b001, 32'h8000_0012, 32'h1234_ABCD, 0, 0,
           3, 32'h0, 0, 0, 1, 8'h0C, 32'hABCD_0000);
      xact("sb", 1, 3'b000, 32'h8000_0007, 32'h0000_00A5, 0, 0,
           3, 32'h0, 0, 0, 1, 8'h08, 32'hA500_0000);
      xact("mis_sh", 1, 3'b001, 32'h8000_0001, 32'hFFFF_FFFF, 0, 0,
           1, 32'h0, 1, 0, 0, 0, 0);
      xact("b2b_lhu", 0, 3'b101, 32'h8000_0100, 0, 32'hCAFE_F00D, 0,
           3, 32'h0000_F00D, 0, 2, 0, 0, 0);
      xact("b2b_lb", 0, 3'b000, 32'h8000_0101, 0, 32'h1234_F678, 0,
           3, 32'hFFFF_FFF6, 0, 2, 0, 0, 0);
      xact("f3_011", 0, 3'b011, 32'h8000_0004, 0, 32'h89AB_CDEF, 0,
           3, 32'h89AB_CDEF, 0, 2, 0, 0, 0);
      xact("f3_011_mis", 0, 3'b011, 32'h8000_0001, 0, 32'h0, 0,
           1, 32'h0, 1, 0, 0, 0, 0);
      xact("hold", 0, 3'b010, 32'h8000_0008, 0, 32'h0102_0304, 3,
           3, 32'h0102_0304, 0, 2, 0, 0, 0);

      // Reset while in RD: outputs drop before any clock edge.
      mm.mem_rdata  = 32'h7777_7777;
      rq.req_valid  = 1'b1;
      rq.req_wen    = 1'b0;
      rq.req_funct3 = 3'b010;
      rq.req_addr   = 32'h8000_0040;
      rq.req_wdata  = 32'h0000_0055;
      step();
      rq.req_valid = 1'b0;
      check("ar_pre_ren", 32'(mm.mem_ren), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("ar_strobes",
            {29'd0, mm.mem_ren, mm.mem_wen, rq.resp_valid}, 32'd0);
      check("ar_ready", 32'(rq.req_ready), 32'd1);
      check("ar_addr", mm.mem_addr, 32'd0);
      check("ar_wdata", mm.mem_wdata, 32'd0);
      step();
      rst = 1'b1;
      step();
      xact("ar_sw", 1, 3'b010, 32'h8000_0020, 32'h1122_3344, 0, 0,
           3, 32'h0, 0, 0, 1, 8'h0F, 32'h1122_3344);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
